// File: rtl/axi_gran_pkg.sv
// Shared types for the granular burst splitter: B channel layout, resp flags
// and the priority merge used when many downstream responses fold into one.
package axi_gran_pkg;

  localparam int ID_W   = 4;
  localparam int USER_W = 1;

  typedef logic [8:0] num_splits_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [1:0]        resp;
    logic [USER_W-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic seen_okay;
    logic seen_exokay;
    logic seen_slverr;
    logic seen_decerr;
  } resp_flags_t;

  function automatic resp_flags_t resp_to_flags(input logic [1:0] resp);
    resp_flags_t f;
    f = '0;
    case (resp)
      RESP_OKAY:   f.seen_okay   = 1'b1;
      RESP_EXOKAY: f.seen_exokay = 1'b1;
      RESP_SLVERR: f.seen_slverr = 1'b1;
      default:     f.seen_decerr = 1'b1;
    endcase
    return f;
  endfunction

  // Worst response wins; EXOKAY survives only if every beat was EXOKAY.
  function automatic logic [1:0] merge_resp(input resp_flags_t f);
    if (f.seen_decerr)      return RESP_DECERR;
    else if (f.seen_slverr) return RESP_SLVERR;
    else if (f.seen_okay)   return RESP_OKAY;
    else                    return RESP_EXOKAY;
  endfunction

endpackage

// File: rtl/axi_gran_b_joiner_table.sv
// Transaction table for the B joiner: entries, age matrix, per-ID head
// lookup, lowest-free allocation and per-beat update/free.
module axi_gran_b_joiner_table
  import axi_gran_pkg::*;
#(
  parameter int IdWidth = 4,
  parameter int MaxTxns = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IdWidth-1:0] alloc_id_i,
  input  num_splits_t        alloc_splits_i,
  input  logic               alloc_valid_i,
  output logic               alloc_ready_o,
  input  logic [IdWidth-1:0] lookup_id_i,
  output logic               head_found_o,
  output logic               head_last_o,
  output resp_flags_t        head_flags_o,
  input  logic               upd_i,
  input  logic [1:0]         upd_resp_i,
  input  logic [USER_W-1:0]  upd_user_i,
  output logic               any_valid_o
);

  localparam int IdxW = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;

  logic [MaxTxns-1:0] r_valid;
  logic [MaxTxns-1:0] r_older [MaxTxns];  // r_older[i][j]: entry j is older than i
  logic [IdWidth-1:0] r_id    [MaxTxns];
  num_splits_t        r_remaining [MaxTxns];
  resp_flags_t        r_flags [MaxTxns];
  logic [USER_W-1:0]  r_user  [MaxTxns];

  logic [MaxTxns-1:0] w_match;
  logic [MaxTxns-1:0] w_head;
  logic [IdxW-1:0]    w_head_idx;
  logic [IdxW-1:0]    w_free_idx;
  logic               w_alloc;

  // NOTE: every variable gets a default before the loops so no latch is inferred.
  always_comb begin
    w_match    = '0;
    w_head     = '0;
    w_head_idx = '0;
    w_free_idx = '0;
    for (int i = 0; i < MaxTxns; i++) begin
      w_match[i] = r_valid[i] && (r_id[i] == lookup_id_i);
    end
    for (int i = 0; i < MaxTxns; i++) begin
      w_head[i] = w_match[i] && ((r_older[i] & w_match) == '0);
      if (w_head[i]) w_head_idx = IdxW'(i);
    end
    for (int i = MaxTxns - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_free_idx = IdxW'(i);
    end
  end

  assign alloc_ready_o = ~&r_valid;
  assign any_valid_o   = |r_valid;
  assign w_alloc       = alloc_valid_i && alloc_ready_o;
  assign head_found_o  = |w_head;
  assign head_last_o   = (r_remaining[w_head_idx] == num_splits_t'(1));
  assign head_flags_o  = r_flags[w_head_idx];

  // NOTE: only valid bits and the age matrix are reset; payload is don't-care while invalid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
      for (int i = 0; i < MaxTxns; i++) r_older[i] <= '0;
    end else begin
      if (upd_i) begin
        if (head_last_o) begin
          r_valid[w_head_idx] <= 1'b0;
        end else begin
          r_remaining[w_head_idx] <= r_remaining[w_head_idx] - num_splits_t'(1);
          r_flags[w_head_idx]     <= r_flags[w_head_idx] | resp_to_flags(upd_resp_i);
          r_user[w_head_idx]      <= upd_user_i;
        end
      end
      if (w_alloc) begin
        r_valid[w_free_idx]     <= 1'b1;
        r_id[w_free_idx]        <= alloc_id_i;
        r_remaining[w_free_idx] <= (alloc_splits_i == '0) ? num_splits_t'(1) : alloc_splits_i;
        r_flags[w_free_idx]     <= '0;
        r_user[w_free_idx]      <= '0;
        // New entry is younger than all live ones; nobody may see its slot as older.
        r_older[w_free_idx]     <= r_valid;
        for (int i = 0; i < MaxTxns; i++) r_older[i][w_free_idx] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_gran_burst_b_joiner.sv
// Collects the N downstream B beats of each split write burst and emits one
// merged upstream B from a registered output stage.
module axi_gran_burst_b_joiner
  import axi_gran_pkg::*;
#(
  parameter int  IdWidth  = ID_W,
  parameter int  MaxTxns  = 4,
  parameter type b_chan_t = axi_gran_pkg::b_chan_t,
  parameter type id_t     = logic [IdWidth-1:0]
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  id_t         alloc_id_i,
  input  num_splits_t alloc_splits_i,
  input  logic        alloc_valid_i,
  output logic        alloc_ready_o,
  input  b_chan_t     b_i,
  input  logic        b_valid_i,
  output logic        b_ready_o,
  output b_chan_t     b_o,
  output logic        b_valid_o,
  input  logic        b_ready_i,
  output logic        unexp_o,
  output logic        busy_o
);

  logic        w_found;
  logic        w_last;
  resp_flags_t w_flags;
  logic        w_any_valid;
  logic        w_upd;
  logic        w_load;

  b_chan_t     r_b;
  logic        r_b_valid;
  logic        r_unexp;

  axi_gran_b_joiner_table #(
    .IdWidth (IdWidth),
    .MaxTxns (MaxTxns)
  ) u_table (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .alloc_id_i     (alloc_id_i),
    .alloc_splits_i (alloc_splits_i),
    .alloc_valid_i  (alloc_valid_i),
    .alloc_ready_o  (alloc_ready_o),
    .lookup_id_i    (b_i.id),
    .head_found_o   (w_found),
    .head_last_o    (w_last),
    .head_flags_o   (w_flags),
    .upd_i          (w_upd),
    .upd_resp_i     (b_i.resp),
    .upd_user_i     (b_i.user),
    .any_valid_o    (w_any_valid)
  );

  // Only a final beat needs room in the output register.
  assign b_ready_o = !w_found || !w_last || !r_b_valid || b_ready_i;
  assign w_upd     = b_valid_i && b_ready_o && w_found;
  assign w_load    = w_upd && w_last;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_b       <= '0;
      r_b_valid <= 1'b0;
      r_unexp   <= 1'b0;
    end else begin
      r_unexp <= b_valid_i && !w_found;
      if (w_load) begin
        r_b.id    <= b_i.id;
        r_b.resp  <= merge_resp(w_flags | resp_to_flags(b_i.resp));
        r_b.user  <= b_i.user;
        r_b_valid <= 1'b1;
      end else if (b_ready_i) begin
        r_b_valid <= 1'b0;
      end
    end
  end

  assign b_o       = r_b;
  assign b_valid_o = r_b_valid;
  assign unexp_o   = r_unexp;
  assign busy_o    = w_any_valid || r_b_valid;

endmodule
